// File: rtl/ta_adc_pkg.sv
// ta_adc_pkg
// Shared definitions for the ADC capture block: capture FSM state encoding,
// default sample width, default RAM address width and default pre-trigger
// depth. No ports.
package ta_adc_pkg;

   localparam int ADC_W_DEF = 14;
   localparam int AW_DEF    = 10;
   localparam int PRE_DEF   = 256;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PREFILL   = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      READ      = 3'd4
   } cap_state_e;

   // Every state except IDLE counts as busy.
   function automatic logic state_is_busy(input cap_state_e s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/ta_capture_ram.sv
// ta_capture_ram
// Simple dual-port capture RAM: one write port and one registered read port
// on the same clock, written so it maps onto block RAM. Contents are not
// reset.
// Ports:
//   clk250_i  in   sample clock
//   we_i      in   write enable
//   waddr_i   in   write address
//   wdata_i   in   write data
//   re_i      in   read enable; rdata_o updates on the next edge
//   raddr_i   in   read address
//   rdata_o   out  registered read data (1-cycle latency)
module ta_capture_ram
   import ta_adc_pkg::*;
#(
   parameter int DW = ADC_W_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk250_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk250_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= mem[raddr_i];
      end
   end

endmodule

// File: rtl/ta_adc_capture.sv
// ta_adc_capture
// Circular-buffer capture of the registered ADC sample stream. After arm the
// buffer is prefilled with PRE samples, then a level crossing (or a forced
// trigger) freezes a 2**AW sample window with PRE samples of history, which
// is streamed out oldest-first on a valid/ready port.
// Optional feature macro: CAPTURE_OF_TAG_EN -- stores adc_of alongside each
// sample, returns it in rd_data[ADC0_0] and adds a rising-edge trigger on it.
// Without the macro rd_data[ADC0_0] is 0 and adc_of is ignored.
// Ports:
//   clk250      in   sample clock
//   rst         in   synchronous active-high reset
//   adc_data    in   unsigned sample, valid every cycle
//   adc_of      in   overflow flag aligned with adc_data
//   arm         in   pulse, starts a capture from IDLE
//   force_trig  in   software trigger, WAIT_TRIG only
//   trig_level  in   rising-edge threshold
//   busy        out  capture in progress
//   done        out  window frozen and being read
//   trig_addr   out  RAM address of the trigger sample
//   rd_valid    out  readout beat valid
//   rd_ready    in   readout consumer ready
//   rd_data     out  {of_tag, sample}
//   rd_last     out  final beat of the window
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | free-running writes, waiting for arm
// PREFILL   | writing PRE samples of history, triggers ignored
// WAIT_TRIG | free-running writes, watching for a trigger
// POST      | writing the remainder of the window after the trigger
// READ      | writes stopped, window streamed out oldest-first
module ta_adc_capture
   import ta_adc_pkg::*;
#(
   parameter int ADC0_0 = ADC_W_DEF,
   parameter int AW     = AW_DEF,
   parameter int PRE    = PRE_DEF
) (
   input  logic              clk250,
   input  logic              rst,
   input  logic [ADC0_0-1:0] adc_data,
   input  logic              adc_of,
   input  logic              arm,
   input  logic              force_trig,
   input  logic [ADC0_0-1:0] trig_level,
   output logic              busy,
   output logic              done,
   output logic [AW-1:0]     trig_addr,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [ADC0_0:0]   rd_data,
   output logic              rd_last
);

   localparam int DEPTH = 2**AW;
`ifdef CAPTURE_OF_TAG_EN
   localparam int RW = ADC0_0 + 1;
`else
   localparam int RW = ADC0_0;
`endif

   localparam logic [AW-1:0] PRE_A      = AW'(PRE);
   localparam logic [AW-1:0] POST_CNT   = AW'(DEPTH - PRE - 1);
   localparam logic [AW:0]   DEPTH_BEAT = (AW+1)'(DEPTH);

   cap_state_e state_q, state_d;

   logic [ADC0_0-1:0] adc_q, adc_prev_q;
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     trig_addr_q, trig_addr_d;
   logic [AW-1:0]     raddr_q, raddr_d;
   logic [AW:0]       rd_left_q, rd_left_d;
   logic              pend_q, pend_d;
   logic              pend_last_q, pend_last_d;
   logic              out_valid_q, out_valid_d;
   logic [ADC0_0:0]   out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              skid_valid_q, skid_valid_d;
   logic [ADC0_0:0]   skid_data_q, skid_data_d;
   logic              skid_last_q, skid_last_d;

   logic              ram_we, ram_re;
   logic [RW-1:0]     ram_wdata, ram_rdata;
   logic [ADC0_0:0]   ram_word;
   logic              lvl_hit, of_hit, trig;
   logic              pop, issue;
   logic [1:0]        occ;

   // Input register: the sample written each cycle is the one that arrived
   // the cycle before; adc_prev_q is the sample written the cycle before that.
   always_ff @(posedge clk250) begin
      if (rst) begin
         adc_q      <= '0;
         adc_prev_q <= '0;
      end else begin
         adc_q      <= adc_data;
         adc_prev_q <= adc_q;
      end
   end

`ifdef CAPTURE_OF_TAG_EN
   logic of_q, of_prev_q;

   always_ff @(posedge clk250) begin
      if (rst) begin
         of_q      <= 1'b0;
         of_prev_q <= 1'b0;
      end else begin
         of_q      <= adc_of;
         of_prev_q <= of_q;
      end
   end

   assign ram_wdata = {of_q, adc_q};
   assign ram_word  = ram_rdata;
   assign of_hit    = of_q & ~of_prev_q;
`else
   logic unused_of;
   assign unused_of = adc_of;
   assign ram_wdata = adc_q;
   assign ram_word  = {1'b0, ram_rdata};
   assign of_hit    = 1'b0;
`endif

   assign lvl_hit = (adc_prev_q < trig_level) && (adc_q >= trig_level);
   assign trig    = lvl_hit | of_hit | force_trig;

   ta_capture_ram #(
      .DW (RW),
      .AW (AW)
   ) u_ram (
      .clk250_i (clk250),
      .we_i     (ram_we),
      .waddr_i  (wptr_q),
      .wdata_i  (ram_wdata),
      .re_i     (ram_re),
      .raddr_i  (raddr_q),
      .rdata_o  (ram_rdata)
   );

   always_comb begin
      state_d      = state_q;
      wptr_d       = wptr_q;
      cnt_d        = cnt_q;
      trig_addr_d  = trig_addr_q;
      raddr_d      = raddr_q;
      rd_left_d    = rd_left_q;
      pend_d       = 1'b0;
      pend_last_d  = pend_last_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_last_d  = skid_last_q;
      ram_we       = 1'b0;
      ram_re       = 1'b0;

      pop = out_valid_q & rd_ready;
      // Entries held or in flight once this cycle's pop is accounted for;
      // a read is issued only when the output stage can still absorb it.
      occ = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q}
            - {1'b0, pop};
      issue = (state_q == READ) && (rd_left_q != '0) && (occ < 2'd2);

      unique case (state_q)
         IDLE: begin
            ram_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (arm) begin
               state_d = PREFILL;
               cnt_d   = PRE_A;
            end
         end
         PREFILL: begin
            ram_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == AW'(1)) begin
               state_d = WAIT_TRIG;
            end
         end
         WAIT_TRIG: begin
            ram_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (trig) begin
               trig_addr_d = wptr_q;
               cnt_d       = POST_CNT;
               state_d     = POST;
            end
         end
         POST: begin
            ram_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == AW'(1)) begin
               state_d   = READ;
               raddr_d   = trig_addr_q - PRE_A;
               rd_left_d = DEPTH_BEAT;
            end
         end
         READ: begin
            if (pop && out_last_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         ram_re      = 1'b1;
         raddr_d     = raddr_q + 1'b1;
         rd_left_d   = rd_left_q - 1'b1;
         pend_d      = 1'b1;
         pend_last_d = (rd_left_q == (AW+1)'(1));
      end

      // Output stage refills from the skid first so ordering is preserved.
      if (!out_valid_q || pop) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_last_d   = skid_last_q;
            skid_valid_d = pend_q;
            skid_data_d  = ram_word;
            skid_last_d  = pend_last_q;
         end else if (pend_q) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_word;
            out_last_d  = pend_last_q;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (pend_q) begin
         skid_valid_d = 1'b1;
         skid_data_d  = ram_word;
         skid_last_d  = pend_last_q;
      end
   end

   always_ff @(posedge clk250) begin
      if (rst) begin
         state_q      <= IDLE;
         wptr_q       <= '0;
         cnt_q        <= '0;
         trig_addr_q  <= '0;
         raddr_q      <= '0;
         rd_left_q    <= '0;
         pend_q       <= 1'b0;
         pend_last_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         cnt_q        <= cnt_d;
         trig_addr_q  <= trig_addr_d;
         raddr_q      <= raddr_d;
         rd_left_q    <= rd_left_d;
         pend_q       <= pend_d;
         pend_last_q  <= pend_last_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_last_q  <= skid_last_d;
      end
   end

   assign busy      = state_is_busy(state_q);
   assign done      = (state_q == READ);
   assign trig_addr = trig_addr_q;
   assign rd_valid  = out_valid_q;
   assign rd_data   = out_data_q;
   assign rd_last   = out_last_q;

endmodule

// File: tb/tb_ta_adc_capture.sv
// tb_ta_adc_capture
// Directed bench for ta_adc_capture with DEPTH=16, PRE=4. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_ta_adc_capture;

   localparam int W   = 14;
   localparam int AW  = 4;
   localparam int PRE = 4;

   logic          clk250 = 1'b0;
   logic          rst;
   logic [W-1:0]  adc_data;
   logic          adc_of;
   logic          arm;
   logic          force_trig;
   logic [W-1:0]  trig_level;
   logic          busy;
   logic          done;
   logic [AW-1:0] trig_addr;
   logic          rd_valid;
   logic          rd_ready;
   logic [W:0]    rd_data;
   logic          rd_last;

   int n_chk     = 0;
   int n_fail    = 0;
   int n_smp     = 0;
   int smode     = 0;
   int of_sample = -1;

   always #5 clk250 = ~clk250;

   ta_adc_capture #(
      .ADC0_0 (W),
      .AW     (AW),
      .PRE    (PRE)
   ) dut (
      .clk250     (clk250),
      .rst        (rst),
      .adc_data   (adc_data),
      .adc_of     (adc_of),
      .arm        (arm),
      .force_trig (force_trig),
      .trig_level (trig_level),
      .busy       (busy),
      .done       (done),
      .trig_addr  (trig_addr),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_data    (rd_data),
      .rd_last    (rd_last)
   );

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One cycle: wait for the falling edge, then drive the next sample.
   // smode 1 gives 0,1,2,3 followed by a constant 100.
   task automatic cyc(input logic a, input logic f);
      int v;
      @(negedge clk250);
      v          = (smode == 1 && n_smp >= 4) ? 100 : n_smp;
      adc_data   = W'(v);
      adc_of     = (v == of_sample);
      arm        = a;
      force_trig = f;
      n_smp++;
   endtask

   // Collect the readout window. Beat i expects cval (if >= 0) or first+i,
   // with the tag bit set only on tag_beat. stop_after > 0 returns right
   // after that many beats have been accepted.
   task automatic read_window(input int first, input int cval, input bit bp,
                              input int tag_beat, input int stop_after,
                              input string tn);
      int beats    = 0;
      int cyc_n    = 0;
      int done_cyc = -1;
      bit lat_seen = 0;
      bit stalled  = 0;
      logic [W:0] sd = '0;
      logic       sl = 1'b0;
      int exp_d;
      while (beats < 16 && cyc_n < 400) begin
         cyc(1'b0, 1'b0);
         cyc_n++;
         rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (done && done_cyc < 0) done_cyc = cyc_n;
         if (stalled) begin
            chk({tn, "_stall_valid"}, 32'(rd_valid), 32'd1);
            chk({tn, "_stall_data"}, 32'(rd_data), 32'(sd));
            chk({tn, "_stall_last"}, 32'(rd_last), 32'(sl));
         end
         if (rd_valid && !lat_seen) begin
            lat_seen = 1;
            chk({tn, "_first_valid_lat_ok"},
                32'((done_cyc >= 0) && (cyc_n - done_cyc) <= 3), 32'd1);
         end
         if (rd_valid && rd_ready) begin
            exp_d = (cval >= 0) ? cval : first + beats;
            if (beats == tag_beat) exp_d = exp_d | (1 << W);
            chk({tn, "_data"}, 32'(rd_data), 32'(exp_d));
            chk({tn, "_last"}, 32'(rd_last), 32'(beats == 15));
            chk({tn, "_done"}, 32'(done), 32'd1);
            beats++;
            stalled = 0;
            if (stop_after > 0 && beats == stop_after) return;
         end else begin
            stalled = rd_valid;
            sd      = rd_data;
            sl      = rd_last;
         end
      end
      chk({tn, "_beats"}, 32'(beats), 32'd16);
      rd_ready = 1'b1;
      cyc(1'b0, 1'b0);
      chk({tn, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tn, "_idle_done"}, 32'(done), 32'd0);
      chk({tn, "_idle_valid"}, 32'(rd_valid), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      arm        = 1'b0;
      force_trig = 1'b0;
      rd_ready   = 1'b1;
      adc_data   = '0;
      adc_of     = 1'b0;
      trig_level = W'(10);

      repeat (3) cyc(1'b0, 1'b0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_trig_addr", 32'(trig_addr), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_data", 32'(rd_data), 32'd0);
      chk("rst_last", 32'(rd_last), 32'd0);
      rst = 1'b0;
      repeat (2) cyc(1'b0, 1'b0);

      // Level trigger on 10: window 6..21.
      trig_level = W'(10);
      n_smp = 0;
      cyc(1'b1, 1'b0);
      read_window(6, -1, 0, -1, 0, "lvl");

      // Forced trigger while sample 40 is written: window 36..51.
      trig_level = W'(16383);
      n_smp = 0;
      cyc(1'b1, 1'b0);
      repeat (40) cyc(1'b0, 1'b0);
      chk("force_pre_busy", 32'(busy), 32'd1);
      chk("force_pre_done", 32'(done), 32'd0);
      cyc(1'b0, 1'b1);
      read_window(36, -1, 0, -1, 0, "force");

      // Crossing of level 2 happens only during prefill; no trigger follows.
      smode      = 1;
      trig_level = W'(2);
      n_smp = 0;
      cyc(1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         cyc(1'b0, 1'b0);
         if (i == 5 || i == 20 || i == 39) begin
            chk("guard_busy", 32'(busy), 32'd1);
            chk("guard_done", 32'(done), 32'd0);
         end
      end
      cyc(1'b0, 1'b1);
      read_window(0, 100, 0, -1, 0, "guard");
      smode = 0;

      // Random backpressure.
      trig_level = W'(10);
      n_smp = 0;
      cyc(1'b1, 1'b0);
      read_window(6, -1, 1, -1, 0, "bp");

      // Reset after beat 7, then a fresh capture.
      n_smp = 0;
      cyc(1'b1, 1'b0);
      read_window(6, -1, 0, -1, 7, "pre_rst");
      cyc(1'b0, 1'b0);
      rst = 1'b1;
      cyc(1'b0, 1'b0);
      chk("midrst_valid", 32'(rd_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      rst = 1'b0;
      cyc(1'b0, 1'b0);
      n_smp = 0;
      cyc(1'b1, 1'b0);
      read_window(6, -1, 0, -1, 0, "rearm");

      // Overflow flag on sample 8.
      trig_level = W'(16383);
      of_sample  = 8;
      n_smp = 0;
      cyc(1'b1, 1'b0);
`ifdef CAPTURE_OF_TAG_EN
      read_window(4, -1, 0, 4, 0, "oftag");
`else
      repeat (12) cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      read_window(8, -1, 0, -1, 0, "oftag_off");
`endif
      of_sample = -1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
